// File: rtl/mux_input_scheduler_if.sv
// Bus bundle between the frame-slot scheduler and its sync source / tx_data consumer.
// The scheduler takes the master side; the sync source / frame assembler takes the slave side.
interface mux_input_scheduler_if #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned VALUE_WIDTH = 16
);
  logic                              sync;
  logic [NUM_INPUTS*VALUE_WIDTH-1:0] values;
  logic [VALUE_WIDTH-1:0]            frame_value;
  logic [7:0]                        frame_id;
  logic                              frame_strobe;
  logic                              timeout;

  modport master (
    input  sync, values,
    output frame_value, frame_id, frame_strobe, timeout
  );

  modport slave (
    output sync, values,
    input  frame_value, frame_id, frame_strobe, timeout
  );
endinterface

// File: rtl/mux_input_scheduler.sv
// Publishes one multiplexed input (value + ID) per interface frame sync edge, plus a sync watchdog.
// Optional macro CHANGE_PRIO_EN: prefer slots whose value changed since they were last published.
module mux_input_scheduler #(
  parameter int unsigned NUM_INPUTS  = 4,
  parameter int unsigned VALUE_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 2700000
) (
  input logic                clk,
  input logic                rst_n,
  mux_input_scheduler_if.master bus
);

  localparam int unsigned PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [2:0]             syncr;
  logic                   sync_edge;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       rr_nxt;
  logic [PTR_W-1:0]       nxt;
  logic [CNT_W-1:0]       cnt;
  logic [VALUE_WIDTH-1:0] slot [NUM_INPUTS];

  assign sync_edge = (syncr[2:1] == 2'b01);

  always_comb begin
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      slot[k] = bus.values[k*VALUE_WIDTH +: VALUE_WIDTH];
    end
  end

`ifdef CHANGE_PRIO_EN
  logic [VALUE_WIDTH-1:0] shadow [NUM_INPUTS];
  logic [PTR_W-1:0]       idx;
  logic                   found;

  // Walk the slots cyclically starting after ptr; the first changed one wins.
  always_comb begin
    rr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
    nxt    = rr_nxt;
    idx    = rr_nxt;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (!found && (slot[idx] != shadow[idx])) begin
        nxt   = idx;
        found = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
        shadow[k] <= '0;
      end
    end else if (sync_edge) begin
      shadow[nxt] <= slot[nxt];
    end
  end
`else
  always_comb begin
    rr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
    nxt    = rr_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncr            <= '0;
      ptr              <= LAST;
      cnt              <= '0;
      bus.frame_value  <= '0;
      bus.frame_id     <= '0;
      bus.frame_strobe <= 1'b0;
      bus.timeout      <= 1'b0;
    end else begin
      syncr            <= {syncr[1:0], bus.sync};
      bus.frame_strobe <= sync_edge;
      if (sync_edge) begin
        ptr             <= nxt;
        bus.frame_id    <= 8'(nxt);
        bus.frame_value <= slot[nxt];
        cnt             <= '0;
        bus.timeout     <= 1'b0;
      end else if (cnt < LIMIT) begin
        cnt         <= cnt + 1'b1;
        bus.timeout <= 1'b0;
      end else begin
        bus.timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_input_scheduler.sv
// Randomized scoreboard bench for mux_input_scheduler (3 slots, 16-bit values, TIMEOUT=20).
module tb_mux_input_scheduler;
  localparam int unsigned N   = 3;
  localparam int unsigned VW  = 16;
  localparam int unsigned TO  = 20;
  localparam int          LAT = 3;  // posedges from sync rise to published outputs

  typedef struct {
    int unsigned    id;
    logic [VW-1:0]  val;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  exp_t          q[$];
  logic [VW-1:0] slot_v [N];
  logic [VW-1:0] shadow [N];
  int unsigned   m_ptr;
  int unsigned   hold_id;
  logic [VW-1:0] hold_val;
  int            anchor;
  int            edge_cyc;

  mux_input_scheduler_if #(.NUM_INPUTS(N), .VALUE_WIDTH(VW)) bus ();

  mux_input_scheduler #(.NUM_INPUTS(N), .VALUE_WIDTH(VW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input longint act, input longint req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_values();
    for (int k = 0; k < N; k++) bus.values[k*VW +: VW] = slot_v[k];
  endtask

  // Reference selection: first changed slot after the last one published, else plain rotation.
  function automatic int unsigned model_pick();
    int unsigned pick;
    pick = (m_ptr + 1) % N;
`ifdef CHANGE_PRIO_EN
    for (int unsigned i = 1; i <= N; i++) begin
      if (slot_v[(m_ptr + i) % N] != shadow[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
`endif
    return pick;
  endfunction

  task automatic model_reset();
    m_ptr    = N - 1;
    hold_id  = 0;
    hold_val = '0;
    for (int k = 0; k < N; k++) shadow[k] = '0;
    q.delete();
  endtask

  task automatic pulse(input int width);
    exp_t e;
    @(posedge clk); #1;
    bus.sync = 1'b1;
    m_ptr = model_pick();
    shadow[m_ptr] = slot_v[m_ptr];
    e.id = m_ptr; e.val = slot_v[m_ptr]; e.cyc = cyc + LAT;
    q.push_back(e);
    edge_cyc = cyc + LAT;
    repeat (width) @(posedge clk);
    #1 bus.sync = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every strobe, otherwise checks outputs hold and the watchdog.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_outputs", {bus.frame_strobe, bus.timeout, bus.frame_id, bus.frame_value}, 0);
    end else begin
      if (cyc == edge_cyc) anchor = cyc;
      check("timeout", bus.timeout, ((cyc - anchor) >= int'(TO + 1)) ? 1 : 0);
      if (bus.frame_strobe) begin
        if (q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("frame_id", bus.frame_id, e.id);
          check("frame_value", bus.frame_value, e.val);
          hold_id  = e.id;
          hold_val = e.val;
        end
      end else begin
        check("hold_id", bus.frame_id, hold_id);
        check("hold_value", bus.frame_value, hold_val);
        if (q.size() != 0 && q[0].cyc < cyc) begin
          check("missing_strobe", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int width, gap, k;
    edge_cyc = -1;
    anchor   = 0;
    bus.sync = 1'b0;
    slot_v[0] = 16'h1111; slot_v[1] = 16'h2222; slot_v[2] = 16'h3333;
    drive_values();
    model_reset();

    // Sync activity during reset must be ignored.
    repeat (3) begin
      repeat (4) @(posedge clk);
      #1 bus.sync = ~bus.sync;
    end
    #1 bus.sync = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1; anchor = cyc;

    // Watchdog from reset, then four plain pulses covering a full wrap.
    repeat (30) @(posedge clk);
    repeat (4) begin
      pulse(1);
      repeat (36) @(posedge clk);
    end

    // Sync held high: exactly one advance.
    pulse(100);
    repeat (10) @(posedge clk);

`ifdef CHANGE_PRIO_EN
    // Bring ptr to slot 2, then dirty slot 1 only: it must jump ahead of clean slot 0.
    while (m_ptr != 2) begin pulse(1); repeat (10) @(posedge clk); end
    #1 slot_v[1] = 16'h2BBB; drive_values();
    pulse(1); repeat (10) @(posedge clk);
    pulse(1); repeat (10) @(posedge clk);
`endif

    // Randomized pulse widths, gaps and value changes.
    for (int n = 0; n < 40; n++) begin
      width = $urandom_range(1, 6);
      gap   = $urandom_range(2, 30);
      pulse(width);
      repeat (4) @(posedge clk);
      #1;
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, N - 1);
        slot_v[k] = ($urandom_range(0, 3) == 0) ? shadow[k] : VW'($urandom);
        drive_values();
      end
      repeat (gap) @(posedge clk);
    end

    // Async reset while timed out with id 2.
    while (m_ptr != 2) begin pulse(1); repeat (10) @(posedge clk); end
    repeat (TO + 8) @(posedge clk);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_timeout", bus.timeout, 0);
    check("async_rst_id", bus.frame_id, 0);
    check("async_rst_value", bus.frame_value, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; anchor = cyc;
    pulse(1);
    repeat (10) @(posedge clk);
    check("after_reset_ptr_model", m_ptr, 0);
    check("after_reset_id", bus.frame_id, 0);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
